// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup by fetch PC,
// registered training from execute with per-set round-robin replacement.
module btb_assoc #(
    parameter int PC_W     = 29,
    parameter int TARGET_W = 30,
    parameter int SETS     = 16,
    parameter int WAYS     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_W-1:0]     fetch_PC,
    output logic                hit,
    output logic [TARGET_W-1:0] target,
    output logic [1:0]          btype,
    output logic                taken,
    input  logic                load,
    input  logic [PC_W-1:0]     new_PC,
    input  logic [TARGET_W-1:0] new_target,
    input  logic [1:0]          new_btype,
    input  logic                new_taken,
    input  logic                flush
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                valid_q  [SETS][WAYS];
    logic                valid_d  [SETS][WAYS];
    logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
    logic [TAG_W-1:0]    tag_d    [SETS][WAYS];
    logic [TARGET_W-1:0] target_q [SETS][WAYS];
    logic [TARGET_W-1:0] target_d [SETS][WAYS];
    logic [1:0]          btype_q  [SETS][WAYS];
    logic [1:0]          btype_d  [SETS][WAYS];
    logic [1:0]          ctr_q    [SETS][WAYS];
    logic [1:0]          ctr_d    [SETS][WAYS];
    logic [WAY_W-1:0]    rr_q     [SETS];
    logic [WAY_W-1:0]    rr_d     [SETS];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [WAY_W-1:0] u_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;

    assign f_idx = fetch_PC[IDX_W-1:0];
    assign f_tag = fetch_PC[PC_W-1:IDX_W];
    assign u_idx = new_PC[IDX_W-1:0];
    assign u_tag = new_PC[PC_W-1:IDX_W];

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic up);
        if (up) begin
            ctr_next = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            ctr_next = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
    endfunction

    always_comb begin
        hit    = 1'b0;
        target = '0;
        btype  = 2'b00;
        taken  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag)) begin
                hit    = 1'b1;
                target = target_q[f_idx][w];
                btype  = btype_q[f_idx][w];
                taken  = (btype_q[f_idx][w] != 2'b00) ? 1'b1 : ctr_q[f_idx][w][1];
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        btype_d   = btype_q;
        ctr_d     = ctr_q;
        rr_d      = rr_q;
        u_hit     = 1'b0;
        u_way     = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        victim    = '0;
        // Tags are unique per set, so at most one way matches.
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit = 1'b1;
                u_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[u_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[s][w] = 1'b0;
                end
            end
        end else if (load) begin
            if (u_hit) begin
                target_d[u_idx][u_way] = new_target;
                btype_d[u_idx][u_way]  = new_btype;
                ctr_d[u_idx][u_way]    = ctr_next(ctr_q[u_idx][u_way], new_taken);
            end else begin
                victim = inv_found ? inv_way : rr_q[u_idx];
                if (!inv_found && (WAYS > 1)) begin
                    rr_d[u_idx] = rr_q[u_idx] + WAY_W'(1);
                end
                valid_d[u_idx][victim]  = 1'b1;
                tag_d[u_idx][victim]    = u_tag;
                target_d[u_idx][victim] = new_target;
                btype_d[u_idx][victim]  = new_btype;
                ctr_d[u_idx][victim]    = new_taken ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    ctr_q[s][w]   <= 2'b00;
                end
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
            rr_q    <= rr_d;
        end
    end

    // Payload needs no reset: it is only observable behind a set valid bit.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        btype_q  <= btype_d;
    end

endmodule
